// File: rtl/sensor_umidade.sv
// sensor_umidade: synchronise, debounce and decode three soil probes into a committed 2-bit level.
// Optional `SENSOR_ERR_CNT_EN adds erro_cnt, a saturating count of entries into FAULT.
module sensor_umidade #(
   parameter int DEB_CYCLES    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] sonda,
   output logic [1:0] U,
   output logic       novo,
   output logic       valido,
`ifdef SENSOR_ERR_CNT_EN
   output logic [7:0] erro_cnt,
`endif
   output logic       erro
);
   localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
   localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

   state_t          state_q, state_d;
   logic [2:0]      s1_q, s2_q, deb_q, deb_d, cand_q, cand_d;
   logic [DW-1:0]   dc_q [3];
   logic [DW-1:0]   dc_d [3];
   logic [SW-1:0]   sc_q, sc_d;
   logic [1:0]      u_q, u_d, lvl;
   logic            novo_q, novo_d, valido_q, valido_d, erro_q, erro_d;
   logic            commit, code_ok;

   always_comb begin
      deb_d = deb_q;
      for (int k = 0; k < 3; k++) begin
         dc_d[k] = '0;
         if (s2_q[k] != deb_q[k]) begin
            if (dc_q[k] == DMAX) deb_d[k] = s2_q[k];
            else dc_d[k] = dc_q[k] + 1'b1;
         end
      end
   end

   // sc saturates, so a stable code re-commits every cycle; the FSM makes that idempotent
   always_comb begin
      cand_d = cand_q;
      sc_d   = sc_q;
      commit = 1'b0;
      if (deb_q != cand_q) begin
         cand_d = deb_q;
         sc_d   = '0;
      end else if (sc_q == SMAX) commit = 1'b1;
      else sc_d = sc_q + 1'b1;
   end

   assign code_ok = cand_q inside {3'b000, 3'b001, 3'b011, 3'b111};
   assign lvl     = {cand_q[1], ^cand_q};

   always_comb begin
      state_d  = state_q;
      u_d      = u_q;
      novo_d   = 1'b0;
      valido_d = valido_q;
      erro_d   = erro_q;
      if (commit) begin
         if (!code_ok) begin
            state_d = FAULT;
            erro_d  = 1'b1;
         end else begin
            state_d  = RUN;
            erro_d   = 1'b0;
            valido_d = 1'b1;
            u_d      = lvl;
            novo_d   = (state_q == INIT) || (lvl != u_q);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         deb_q    <= '0;
         cand_q   <= '0;
         sc_q     <= '0;
         for (int k = 0; k < 3; k++) dc_q[k] <= '0;
         state_q  <= INIT;
         u_q      <= '0;
         novo_q   <= 1'b0;
         valido_q <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         s1_q     <= sonda;
         s2_q     <= s1_q;
         deb_q    <= deb_d;
         cand_q   <= cand_d;
         sc_q     <= sc_d;
         for (int k = 0; k < 3; k++) dc_q[k] <= dc_d[k];
         state_q  <= state_d;
         u_q      <= u_d;
         novo_q   <= novo_d;
         valido_q <= valido_d;
         erro_q   <= erro_d;
      end
   end

`ifdef SENSOR_ERR_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else if (erro_d && !erro_q && cnt_q != 8'hFF) cnt_q <= cnt_q + 1'b1;
   end

   assign erro_cnt = cnt_q;
`endif

   assign U      = u_q;
   assign novo   = novo_q;
   assign valido = valido_q;
   assign erro   = erro_q;
endmodule
